// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU slice.
//  - Op-code values driven on Op.
//  - Bit positions of the packed {Z,C,N,O} flag vector.
//  - State encoding of the multiplier sequencer.
package alu_pkg;

    localparam logic [3:0] OP_PASSA = 4'h0;
    localparam logic [3:0] OP_PASSB = 4'h1;
    localparam logic [3:0] OP_NOTA  = 4'h2;
    localparam logic [3:0] OP_NOTB  = 4'h3;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_ADDC  = 4'h5;
    localparam logic [3:0] OP_SUB   = 4'h6;
    localparam logic [3:0] OP_AND   = 4'h7;
    localparam logic [3:0] OP_OR    = 4'h8;
    localparam logic [3:0] OP_XOR   = 4'h9;
    localparam logic [3:0] OP_NAND  = 4'hA;
    localparam logic [3:0] OP_LSL   = 4'hB;
    localparam logic [3:0] OP_LSR   = 4'hC;
    localparam logic [3:0] OP_ASR   = 4'hD;
    localparam logic [3:0] OP_CSL   = 4'hE;
    localparam logic [3:0] OP_MUL   = 4'hF;

    // Flags are packed {Z,C,N,O}
    localparam int FLG_Z = 3;
    localparam int FLG_C = 2;
    localparam int FLG_N = 1;
    localparam int FLG_O = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } mul_state_e;

endpackage

// File: rtl/seq_alu_unit_if.sv
// Request/result bundle between the issuing stage and seq_alu_unit.
//  master: drives Start, Op, FlagWE, A, B; receives Busy, Done, ALUOut, Flags.
//  slave : the ALU itself.
interface seq_alu_unit_if #(
    parameter int WIDTH = 16
);
    logic             Start;
    logic [3:0]       Op;
    logic             FlagWE;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] ALUOut;
    logic [3:0]       Flags;

    modport master (
        output Start, Op, FlagWE, A, B,
        input  Busy, Done, ALUOut, Flags
    );

    modport slave (
        input  Start, Op, FlagWE, A, B,
        output Busy, Done, ALUOut, Flags
    );
endinterface

// File: rtl/seq_mul.sv
// WIDTH-cycle shift-add multiplier.
//  Clock   : rising-edge clock
//  Reset   : asynchronous active-low reset, aborts a running multiply
//  start   : load a/b and begin (only honoured in IDLE)
//  a, b    : operands, captured on the start edge
//  busy    : multiply in progress
//  done    : high during the final iteration; product is valid in that cycle
//  product : full 2*WIDTH-bit product (combinational view of the final add)
module seq_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    mul_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic               last;

    assign last  = (cnt_q == CW'(WIDTH - 1));
    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    // Exposing the next accumulator lets the parent register the result on
    // the same edge the sequencer leaves MUL, giving exactly WIDTH cycles.
    assign product = acc_d;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_MUL;
            ST_MUL:  if (last)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_MUL);
        done = (state_q == ST_MUL) && last;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (state_q == ST_IDLE) begin
            if (start) begin
                cnt_q    <= '0;
                mcand_q  <= {{WIDTH{1'b0}}, a};
                mplier_q <= b;
                acc_q    <= '0;
            end
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= last ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/seq_alu_unit.sv
// Execution stage: single-cycle ALU ops plus a sequential multiply.
//  Clock : rising-edge clock
//  Reset : asynchronous active-low reset
//  bus   : slave side of seq_alu_unit_if
//          in : Start, Op, FlagWE, A, B
//          out: Busy, Done (1-cycle pulse), ALUOut, Flags {Z,C,N,O}
module seq_alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    seq_alu_unit_if.slave bus
);

    localparam int MSB = WIDTH - 1;

    logic               mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic               fire, mul_fire, single_fire;

    logic [WIDTH-1:0]   op_a, op_b, res;
    logic [WIDTH:0]     sum;
    logic               c_res, o_res;
    logic [3:0]         alu_flags, mul_flags;

    logic [WIDTH-1:0]   aluout_q;
    logic [3:0]         flags_q;
    logic               done_q;
    logic               flagwe_q;

    // Start is dropped on the floor while a multiply runs
    assign fire        = bus.Start && !mul_busy;
    assign mul_fire    = fire && (bus.Op == OP_MUL);
    assign single_fire = fire && (bus.Op != OP_MUL);

    assign op_a = bus.A;
    assign op_b = bus.B;

    seq_mul #(.WIDTH(WIDTH)) u_mul (
        .Clock   (Clock),
        .Reset   (Reset),
        .start   (mul_fire),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Single-cycle datapath; C and O default to their held values
    always_comb begin
        res   = '0;
        sum   = '0;
        c_res = flags_q[FLG_C];
        o_res = flags_q[FLG_O];
        case (bus.Op)
            OP_PASSA: res = op_a;
            OP_PASSB: res = op_b;
            OP_NOTA:  res = ~op_a;
            OP_NOTB:  res = ~op_b;
            OP_ADD, OP_ADDC: begin
                sum   = {1'b0, op_a} + {1'b0, op_b}
                      + {{WIDTH{1'b0}}, (bus.Op == OP_ADDC) & flags_q[FLG_C]};
                res   = sum[MSB:0];
                c_res = sum[WIDTH];
                o_res = (op_a[MSB] == op_b[MSB]) && (res[MSB] != op_a[MSB]);
            end
            OP_SUB: begin
                // C is the carry of A + ~B + 1, i.e. 1 means no borrow
                sum   = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
                res   = sum[MSB:0];
                c_res = sum[WIDTH];
                o_res = (op_a[MSB] != op_b[MSB]) && (res[MSB] != op_a[MSB]);
            end
            OP_AND:  res = op_a & op_b;
            OP_OR:   res = op_a | op_b;
            OP_XOR:  res = op_a ^ op_b;
            OP_NAND: res = ~(op_a & op_b);
            OP_LSL: begin
                res   = {op_a[MSB-1:0], 1'b0};
                c_res = op_a[MSB];
            end
            OP_LSR: begin
                res   = {1'b0, op_a[MSB:1]};
                c_res = op_a[0];
            end
            OP_ASR: begin
                res   = {op_a[MSB], op_a[MSB:1]};
                c_res = op_a[0];
            end
            OP_CSL: begin
                res   = {op_a[MSB-1:0], flags_q[FLG_C]};
                c_res = op_a[MSB];
            end
            default: res = '0;
        endcase
    end

    always_comb begin
        alu_flags        = flags_q;
        alu_flags[FLG_Z] = (res == '0);
        alu_flags[FLG_C] = c_res;
        alu_flags[FLG_N] = res[MSB];
        alu_flags[FLG_O] = o_res;

        // Multiply: O flags a product that does not fit; C is left alone
        mul_flags        = flags_q;
        mul_flags[FLG_Z] = (mul_prod[MSB:0] == '0);
        mul_flags[FLG_N] = mul_prod[MSB];
        mul_flags[FLG_O] = (mul_prod[2*WIDTH-1:WIDTH] != '0);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            aluout_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            flagwe_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (mul_fire) flagwe_q <= bus.FlagWE;
            if (single_fire) begin
                aluout_q <= res;
                done_q   <= 1'b1;
                if (bus.FlagWE) flags_q <= alu_flags;
            end else if (mul_done) begin
                aluout_q <= mul_prod[MSB:0];
                done_q   <= 1'b1;
                if (flagwe_q) flags_q <= mul_flags;
            end
        end
    end

    assign bus.Busy   = mul_busy;
    assign bus.Done   = done_q;
    assign bus.ALUOut = aluout_q;
    assign bus.Flags  = flags_q;

endmodule

// File: tb/tb_seq_alu_unit.sv
// Self-checking bench for seq_alu_unit (WIDTH=16): directed scenarios plus
// randomized ops checked against an arithmetic reference model.
module tb_seq_alu_unit;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] m_out;
    logic [3:0]  m_flags;   // {Z,C,N,O}

    always #5 Clock = ~Clock;

    seq_alu_unit_if #(.WIDTH(16)) bus ();

    seq_alu_unit #(.WIDTH(16)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    // Reference model: plain integer arithmetic on the op definitions
    task automatic model_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic fwe);
        int s, sv;
        logic [31:0] p;
        logic [15:0] r;
        logic c, o;
        c = m_flags[2];
        o = m_flags[0];
        r = '0;
        case (op)
            4'h0: r = a;
            4'h1: r = b;
            4'h2: r = ~a;
            4'h3: r = ~b;
            4'h4, 4'h5: begin
                s  = int'(a) + int'(b) + ((op == 4'h5) ? int'(m_flags[2]) : 0);
                sv = int'($signed(a)) + int'($signed(b)) + ((op == 4'h5) ? int'(m_flags[2]) : 0);
                r  = s[15:0];
                c  = (s > 65535);
                o  = (sv > 32767) || (sv < -32768);
            end
            4'h6: begin
                sv = int'($signed(a)) - int'($signed(b));
                r  = a - b;
                c  = (a >= b);
                o  = (sv > 32767) || (sv < -32768);
            end
            4'h7: r = a & b;
            4'h8: r = a | b;
            4'h9: r = a ^ b;
            4'hA: r = ~(a & b);
            4'hB: begin r = a << 1; c = a[15]; end
            4'hC: begin r = a >> 1; c = a[0]; end
            4'hD: begin r = 16'($signed(a) >>> 1); c = a[0]; end
            4'hE: begin r = (a << 1) | {15'd0, m_flags[2]}; c = a[15]; end
            default: begin
                p = 32'(a) * 32'(b);
                r = p[15:0];
                o = (p[31:16] != 0);
            end
        endcase
        m_out = r;
        if (fwe) m_flags = {(r == 0), c, r[15], o};
    endtask

    // Present a request at the falling edge; return just after the sampling edge
    task automatic drive_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic fwe);
        @(negedge Clock);
        bus.Start  = 1'b1;
        bus.Op     = op;
        bus.A      = a;
        bus.B      = b;
        bus.FlagWE = fwe;
        @(posedge Clock);
        #1;
    endtask

    task automatic go_idle();
        @(negedge Clock);
        bus.Start = 1'b0;
    endtask

    // Launch a multiply and wait (bounded) for its Done; optionally fire an
    // ADD while busy, which must be ignored.
    task automatic mul_run(input logic [15:0] a, input logic [15:0] b, input logic fwe,
                           input bit inject, output int lat, output int busy_gaps,
                           output int out_moves);
        logic [15:0] held;
        held = bus.ALUOut;
        drive_op(4'hF, a, b, fwe);
        bus.Start = 1'b0;
        busy_gaps = (bus.Busy !== 1'b1) ? 1 : 0;
        out_moves = 0;
        lat = 0;
        while (lat < 40) begin
            if (inject && lat == 3) begin
                bus.Start = 1'b1; bus.Op = 4'h4; bus.A = 16'h1111; bus.B = 16'h2222; bus.FlagWE = 1'b1;
            end else begin
                bus.Start = 1'b0;
            end
            @(posedge Clock);
            #1;
            lat++;
            if (bus.Done === 1'b1) break;
            if (bus.Busy !== 1'b1) busy_gaps++;
            if (bus.ALUOut !== held) out_moves++;
        end
        bus.Start = 1'b0;
    endtask

    task automatic test_reset();
        bus.Start = 0; bus.Op = 0; bus.A = 0; bus.B = 0; bus.FlagWE = 0;
        Reset = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", bus.Busy); end
        checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", bus.Done); end
        checks++; if (bus.ALUOut !== 16'h0) begin errors++; $display("FAIL reset_out: got %h exp 0000", bus.ALUOut); end
        checks++; if (bus.Flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %b exp 0000", bus.Flags); end
        m_out = '0;
        m_flags = '0;
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic test_add_overflow();
        drive_op(4'h4, 16'h7FFF, 16'h0001, 1'b1);
        model_op(4'h4, 16'h7FFF, 16'h0001, 1'b1);
        checks++; if (bus.Done !== 1'b1) begin errors++; $display("FAIL add_done: got %b exp 1", bus.Done); end
        checks++; if (bus.ALUOut !== 16'h8000) begin errors++; $display("FAIL add_out: got %h exp 8000", bus.ALUOut); end
        checks++; if (bus.Flags !== 4'b0011) begin errors++; $display("FAIL add_flags: got %b exp 0011", bus.Flags); end
        checks++; if (bus.Flags !== m_flags) begin errors++; $display("FAIL add_model_flags: got %b exp %b", bus.Flags, m_flags); end
        go_idle();
        @(posedge Clock); #1;
        checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got %b exp 0", bus.Done); end
    endtask

    task automatic test_sub();
        drive_op(4'h6, 16'h0005, 16'h0005, 1'b1);
        model_op(4'h6, 16'h0005, 16'h0005, 1'b1);
        checks++; if (bus.ALUOut !== 16'h0000) begin errors++; $display("FAIL sub_out: got %h exp 0000", bus.ALUOut); end
        checks++; if (bus.Flags !== 4'b1100) begin errors++; $display("FAIL sub_flags: got %b exp 1100", bus.Flags); end
        drive_op(4'h6, 16'h0003, 16'h0005, 1'b0);
        model_op(4'h6, 16'h0003, 16'h0005, 1'b0);
        checks++; if (bus.ALUOut !== 16'hFFFE) begin errors++; $display("FAIL sub_nofwe_out: got %h exp fffe", bus.ALUOut); end
        checks++; if (bus.Flags !== 4'b1100) begin errors++; $display("FAIL sub_nofwe_flags: got %b exp 1100", bus.Flags); end
        go_idle();
    endtask

    task automatic test_mul_directed();
        int lat, gaps, moves;
        mul_run(16'h0123, 16'h0010, 1'b1, 1'b1, lat, gaps, moves);
        model_op(4'hF, 16'h0123, 16'h0010, 1'b1);
        checks++; if (lat !== 16) begin errors++; $display("FAIL mul_latency: got %0d exp 16", lat); end
        checks++; if (gaps !== 0) begin errors++; $display("FAIL mul_busy_gaps: got %0d exp 0", gaps); end
        checks++; if (moves !== 0) begin errors++; $display("FAIL mul_out_held: got %0d changes exp 0", moves); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL mul_busy_end: got %b exp 0", bus.Busy); end
        checks++; if (bus.ALUOut !== 16'h1230) begin errors++; $display("FAIL mul_out: got %h exp 1230", bus.ALUOut); end
        checks++; if (bus.Flags[0] !== 1'b0) begin errors++; $display("FAIL mul_o: got %b exp 0", bus.Flags[0]); end
        checks++; if (bus.Flags !== m_flags) begin errors++; $display("FAIL mul_flags: got %b exp %b", bus.Flags, m_flags); end
        @(posedge Clock); #1;
        checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse: got %b exp 0", bus.Done); end
    endtask

    task automatic test_carry_chain();
        drive_op(4'h4, 16'hFFFF, 16'h0001, 1'b1);
        model_op(4'h4, 16'hFFFF, 16'h0001, 1'b1);
        checks++; if (bus.Flags[2] !== 1'b1) begin errors++; $display("FAIL setc_c: got %b exp 1", bus.Flags[2]); end
        checks++; if (bus.Flags !== m_flags) begin errors++; $display("FAIL setc_flags: got %b exp %b", bus.Flags, m_flags); end
        drive_op(4'h5, 16'h0001, 16'h0001, 1'b1);
        model_op(4'h5, 16'h0001, 16'h0001, 1'b1);
        checks++; if (bus.ALUOut !== 16'h0003) begin errors++; $display("FAIL addc_out: got %h exp 0003", bus.ALUOut); end
        checks++; if (bus.Flags[2] !== 1'b0) begin errors++; $display("FAIL addc_c: got %b exp 0", bus.Flags[2]); end
        drive_op(4'hE, 16'h8000, 16'h0000, 1'b1);
        model_op(4'hE, 16'h8000, 16'h0000, 1'b1);
        checks++; if (bus.ALUOut !== 16'h0000) begin errors++; $display("FAIL csl_out: got %h exp 0000", bus.ALUOut); end
        checks++; if (bus.Flags[3:2] !== 2'b11) begin errors++; $display("FAIL csl_zc: got %b exp 11", bus.Flags[3:2]); end
        checks++; if (bus.Flags !== m_flags) begin errors++; $display("FAIL csl_flags: got %b exp %b", bus.Flags, m_flags); end
        go_idle();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [4];
        logic [15:0] a, b;
        ops[0] = 4'h7; ops[1] = 4'h8; ops[2] = 4'h9; ops[3] = 4'hD;
        for (int i = 0; i < 4; i++) begin
            a = (i == 3) ? 16'h8001 : 16'($urandom);
            b = 16'($urandom);
            drive_op(ops[i], a, b, 1'b1);
            model_op(ops[i], a, b, 1'b1);
            checks++; if (bus.Done !== 1'b1) begin errors++; $display("FAIL b2b_done[%0d]: got %b exp 1", i, bus.Done); end
            checks++; if (bus.ALUOut !== m_out) begin errors++; $display("FAIL b2b_out[%0d]: got %h exp %h", i, bus.ALUOut, m_out); end
        end
        checks++; if (bus.ALUOut !== 16'hC000) begin errors++; $display("FAIL asr_out: got %h exp c000", bus.ALUOut); end
        checks++; if (bus.Flags[2] !== 1'b1) begin errors++; $display("FAIL asr_c: got %b exp 1", bus.Flags[2]); end
        go_idle();
        @(posedge Clock); #1;
        checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL b2b_done_end: got %b exp 0", bus.Done); end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [15:0] a, b;
        logic        fwe;
        logic [15:0] edge_v [4];
        int lat, gaps, moves;
        edge_v[0] = 16'h0000; edge_v[1] = 16'hFFFF; edge_v[2] = 16'h8000; edge_v[3] = 16'h7FFF;
        for (int i = 0; i < 300; i++) begin
            op  = 4'($urandom_range(0, 15));
            a   = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : 16'($urandom);
            b   = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : 16'($urandom);
            fwe = 1'($urandom);
            if (op == 4'hF) begin
                mul_run(a, b, fwe, 1'b0, lat, gaps, moves);
                model_op(op, a, b, fwe);
                checks++; if (lat !== 16) begin errors++; $display("FAIL rnd_mul_lat[%0d]: got %0d exp 16", i, lat); end
                checks++; if (gaps !== 0) begin errors++; $display("FAIL rnd_mul_busy[%0d]: got %0d gaps exp 0", i, gaps); end
            end else begin
                drive_op(op, a, b, fwe);
                model_op(op, a, b, fwe);
                checks++; if (bus.Done !== 1'b1) begin errors++; $display("FAIL rnd_done[%0d]: got %b exp 1", i, bus.Done); end
            end
            checks++; if (bus.ALUOut !== m_out) begin errors++; $display("FAIL rnd_out[%0d] op %h a %h b %h: got %h exp %h", i, op, a, b, bus.ALUOut, m_out); end
            checks++; if (bus.Flags !== m_flags) begin errors++; $display("FAIL rnd_flags[%0d] op %h a %h b %h: got %b exp %b", i, op, a, b, bus.Flags, m_flags); end
            if ($urandom_range(0, 2) == 0) begin
                go_idle();
                @(posedge Clock); #1;
                checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL rnd_idle_done[%0d]: got %b exp 0", i, bus.Done); end
            end
        end
        go_idle();
    endtask

    task automatic test_reset_mid_mul();
        int late_done;
        drive_op(4'hF, 16'h0123, 16'h0010, 1'b1);
        bus.Start = 1'b0;
        repeat (4) @(posedge Clock);
        #2;
        Reset = 1'b0;
        #1;
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL rstmul_busy: got %b exp 0", bus.Busy); end
        checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL rstmul_done: got %b exp 0", bus.Done); end
        checks++; if (bus.ALUOut !== 16'h0) begin errors++; $display("FAIL rstmul_out: got %h exp 0000", bus.ALUOut); end
        checks++; if (bus.Flags !== 4'h0) begin errors++; $display("FAIL rstmul_flags: got %b exp 0000", bus.Flags); end
        m_out = '0;
        m_flags = '0;
        @(negedge Clock);
        Reset = 1'b1;
        late_done = 0;
        repeat (25) begin
            @(posedge Clock); #1;
            if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) late_done++;
        end
        checks++; if (late_done !== 0) begin errors++; $display("FAIL rstmul_no_done: got %0d active cycles exp 0", late_done); end
        drive_op(4'h4, 16'h1234, 16'h1111, 1'b1);
        model_op(4'h4, 16'h1234, 16'h1111, 1'b1);
        checks++; if (bus.ALUOut !== m_out) begin errors++; $display("FAIL rstmul_recover: got %h exp %h", bus.ALUOut, m_out); end
        go_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add_overflow();
        test_sub();
        test_mul_directed();
        test_carry_chain();
        test_back_to_back();
        test_random();
        test_reset_mid_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
